// File: rtl/morse_decoder.sv
// Morse line decoder: measures mark/space runs per unit tick and maps dot/dash patterns to 3-bit
// letter codes. Define MORSE_DEC_TOLERANT_EN to accept any mark longer than one tick as a dash.
module morse_decoder #(
  parameter int unsigned DASH_UNITS  = 3,
  parameter int unsigned LETTER_GAP  = 3,
  parameter int unsigned MAX_SYMBOLS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       morse_in,
  output logic [2:0] letter,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(MAX_SYMBOLS + 1);
  localparam int unsigned PatW = MAX_SYMBOLS;
  localparam logic [2:0] DashRun = 3'(DASH_UNITS);
  localparam logic [2:0] GapRun  = 3'(LETTER_GAP);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_SYMBOLS);

  typedef enum logic [1:0] {StIdle, StMark, StSpace, StDiscard} state_e;

  state_e            state_q;
  logic [2:0]        run_q;
  logic [CntW-1:0]   count_q;
  logic [PatW-1:0]   pattern_q;

  logic [2:0] run_inc;
  logic       sym_ok;
  logic       sym_dash;
  logic       hit;
  logic [2:0] code;

  always_comb begin
    run_inc = (run_q == 3'd7) ? run_q : run_q + 3'd1;
`ifdef MORSE_DEC_TOLERANT_EN
    sym_dash = (run_q >= 3'd2);
    sym_ok   = (run_q != 3'd0);
`else
    sym_dash = (run_q == DashRun);
    sym_ok   = (run_q == 3'd1) || sym_dash;
`endif
  end

  // Symbols are shifted in at the LSB, so the first symbol ends up furthest left.
  always_comb begin
    hit  = 1'b1;
    code = 3'b000;
    if (count_q == CntW'(3) && pattern_q == PatW'(4'b0000))      code = 3'b000;
    else if (count_q == CntW'(1) && pattern_q == PatW'(4'b0001)) code = 3'b001;
    else if (count_q == CntW'(3) && pattern_q == PatW'(4'b0100)) code = 3'b010;
    else if (count_q == CntW'(4) && pattern_q == PatW'(4'b1000)) code = 3'b011;
    else if (count_q == CntW'(3) && pattern_q == PatW'(4'b0110)) code = 3'b100;
    else if (count_q == CntW'(4) && pattern_q == PatW'(4'b1001)) code = 3'b101;
    else if (count_q == CntW'(4) && pattern_q == PatW'(4'b1101)) code = 3'b110;
    else if (count_q == CntW'(4) && pattern_q == PatW'(4'b0011)) code = 3'b111;
    else                                                         hit  = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      run_q     <= 3'd0;
      count_q   <= '0;
      pattern_q <= '0;
      letter    <= 3'b000;
      valid     <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Pulses clear on every clk, independent of tick.
      valid <= 1'b0;
      err   <= 1'b0;
      if (tick) begin
        unique case (state_q)
          StIdle: begin
            if (morse_in) begin
              state_q <= StMark;
              run_q   <= 3'd1;
              busy    <= 1'b1;
            end
          end
          StMark: begin
            if (morse_in) begin
              run_q <= run_inc;
            end else if (sym_ok && count_q != MaxCnt) begin
              pattern_q <= {pattern_q[PatW-2:0], sym_dash};
              count_q   <= count_q + CntW'(1);
              state_q   <= StSpace;
              run_q     <= 3'd1;
            end else begin
              err     <= 1'b1;
              state_q <= StDiscard;
              run_q   <= 3'd1;
            end
          end
          StSpace: begin
            if (morse_in) begin
              state_q <= StMark;
              run_q   <= 3'd1;
            end else if (run_inc == GapRun) begin
              if (hit) begin
                letter <= code;
                valid  <= 1'b1;
              end else begin
                err <= 1'b1;
              end
              state_q   <= StIdle;
              busy      <= 1'b0;
              run_q     <= 3'd0;
              count_q   <= '0;
              pattern_q <= '0;
            end else begin
              run_q <= run_inc;
            end
          end
          StDiscard: begin
            if (morse_in) begin
              run_q <= 3'd0;
            end else if (run_inc == GapRun) begin
              state_q   <= StIdle;
              busy      <= 1'b0;
              run_q     <= 3'd0;
              count_q   <= '0;
              pattern_q <= '0;
            end else begin
              run_q <= run_inc;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder: feeds bit strings one per tick and checks decoded results.
module tb_morse_decoder;

  logic       clk;
  logic       reset_n;
  logic       tick;
  logic       morse_in;
  logic [2:0] letter;
  logic       valid;
  logic       err;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  // Per-sequence observations
  int nv;
  int ne;
  int vidx;
  int busy_ticks;
  bit cont;
  logic [2:0] exp_letter;

  morse_decoder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .morse_in (morse_in),
    .letter   (letter),
    .valid    (valid),
    .err      (err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One bit per tick; in non-continuous mode an idle clk (tick=0) follows each tick.
  task automatic send(input string bits);
    nv = 0;
    ne = 0;
    vidx = -1;
    busy_ticks = 0;
    for (int i = 0; i < bits.len(); i++) begin
      morse_in = (bits[i] == "1");
      tick = 1'b1;
      @(posedge clk);
      #1;
      if (valid === 1'b1) begin
        nv++;
        vidx = i;
      end
      if (err === 1'b1) ne++;
      if (busy === 1'b1) busy_ticks++;
      if (!cont) begin
        tick = 1'b0;
        @(posedge clk);
        #1;
        if (valid === 1'b1) nv++;
        if (err === 1'b1) ne++;
      end
    end
    tick = 1'b0;
    morse_in = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    tick = 1'b0;
    morse_in = 1'b0;
    cont = 1'b0;
    exp_letter = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_letter", int'(letter), 0);
    check_val("rst_valid", int'(valid), 0);
    check_val("rst_err", int'(err), 0);
    check_val("rst_busy", int'(busy), 0);
    reset_n = 1'b1;

    // S: dot dot dot -> 000, valid on 3rd trailing zero (index 7)
    send("1010100000000000");
    check_val("s_nv", nv, 1);
    check_val("s_ne", ne, 0);
    check_val("s_vidx", vidx, 7);
    check_val("s_letter", int'(letter), 0);

    // dash dot dot dash -> 101; busy for ticks 0..12
    send("1110101011100000");
    check_val("l101_nv", nv, 1);
    check_val("l101_ne", ne, 0);
    check_val("l101_vidx", vidx, 13);
    check_val("l101_letter", int'(letter), 5);
    check_val("l101_busy", busy_ticks, 13);

    // Back-to-back with tick held high continuously
    cont = 1'b1;
    send("1010111011100000");
    check_val("l111_nv", nv, 1);
    check_val("l111_vidx", vidx, 13);
    check_val("l111_letter", int'(letter), 7);
    send("1110111010111000");
    check_val("l110_nv", nv, 1);
    check_val("l110_vidx", vidx, 15);
    check_val("l110_letter", int'(letter), 6);
    check_val("l110_ne", ne, 0);
    cont = 1'b0;
    exp_letter = 3'b110;

    // 2-tick mark
    send("110000");
`ifdef MORSE_DEC_TOLERANT_EN
    exp_letter = 3'b001;
    check_val("mark2_nv", nv, 1);
    check_val("mark2_ne", ne, 0);
`else
    check_val("mark2_nv", nv, 0);
    check_val("mark2_ne", ne, 1);
`endif
    check_val("mark2_letter", int'(letter), int'(exp_letter));

    // dot dash dot: not in table
    send("1011101000");
    check_val("ndn_nv", nv, 0);
    check_val("ndn_ne", ne, 1);
    check_val("ndn_letter", int'(letter), int'(exp_letter));
    check_val("ndn_busy", int'(busy), 0);

    // Five dots: overflow on the 5th, discard, then a dash decodes
    send("101010101000");
    check_val("five_nv", nv, 0);
    check_val("five_ne", ne, 1);
    check_val("five_busy", int'(busy), 0);
    send("1110000");
    check_val("t_nv", nv, 1);
    check_val("t_vidx", vidx, 5);
    check_val("t_letter", int'(letter), 1);
    exp_letter = 3'b001;

    // Stuck-high line: saturating run, outcome on the falling edge
    send("1111111111");
    check_val("stuck_busy", int'(busy), 1);
    check_val("stuck_out", nv + ne, 0);
    send("000");
`ifdef MORSE_DEC_TOLERANT_EN
    check_val("stuck_nv", nv, 1);
    check_val("stuck_ne", ne, 0);
`else
    check_val("stuck_nv", nv, 0);
    check_val("stuck_ne", ne, 1);
`endif
    check_val("stuck_idle", int'(busy), 0);

    // Reset mid-letter
    send("1110111");
    check_val("mid_busy", int'(busy), 1);
    check_val("mid_letter", int'(letter), 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("rstmid_letter", int'(letter), 0);
    check_val("rstmid_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    send("000000");
    check_val("rstmid_nv", nv, 0);
    check_val("rstmid_ne", ne, 0);
    check_val("rstmid_letter2", int'(letter), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
